// File: rtl/move_list_collector.sv
// Move-list collector: snapshots NUM_LANES move words, pushes the non-zero ones into a FIFO
// and streams them out over valid/ready. Define CAPTURE_FIRST_EN to emit captures before quiet moves.
module move_list_collector #(
    parameter int NUM_LANES = 16,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    clear_n,
    input  logic                    start,
    input  logic [NUM_LANES*32-1:0] moves_in,
    output logic                    busy,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [31:0]             m_data,
    output logic [CNT_W-1:0]        move_count,
    output logic                    done
);
    localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN
    } state_t;

    state_t           state, state_nxt;
    logic [31:0]      snap [NUM_LANES];
    logic [31:0]      mem  [DEPTH];
    logic [IDX_W-1:0] idx;
    logic             primed;
    logic [PTR_W:0]   wr_ptr, rd_ptr;

    logic [31:0]      lane_word;
    logic             lane_take, last_lane, final_pass;
    logic             fifo_full, fifo_empty, pop, push_ok;
    logic             snap_load, advance, push, done_nxt;

    assign lane_word = snap[idx];
    assign last_lane = (idx == IDX_W'(NUM_LANES - 1));

`ifdef CAPTURE_FIRST_EN
    // Pass 0 takes captures only, pass 1 takes the remaining non-zero (quiet) words.
    logic pass;

    assign lane_take  = pass ? ((lane_word != 32'd0) && (lane_word[29:24] == 6'd0))
                             : (lane_word[29:24] != 6'd0);
    assign final_pass = pass;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)
            pass <= 1'b0;
        else if (snap_load)
            pass <= 1'b0;
        else if (advance && last_lane)
            pass <= 1'b1;
    end
`else
    assign lane_take  = (lane_word != 32'd0);
    assign final_pass = 1'b1;
`endif

    // Extra pointer bit separates full from empty when the low bits match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign m_valid    = !fifo_empty;
    assign pop        = m_valid && m_ready;
    assign push_ok    = !fifo_full || pop;
    assign m_data     = fifo_empty ? 32'd0 : mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        busy      = (state != S_IDLE);
        snap_load = 1'b0;
        advance   = 1'b0;
        push      = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    snap_load = 1'b1;
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                // First SCAN cycle lets the snapshot settle; a held word stalls idx.
                if (primed && (!lane_take || push_ok)) begin
                    advance = 1'b1;
                    push    = lane_take;
                    if (last_lane && final_pass)
                        state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            idx        <= '0;
            primed     <= 1'b0;
            move_count <= '0;
            done       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            done <= done_nxt;
            if (snap_load) begin
                idx        <= '0;
                primed     <= 1'b0;
                move_count <= '0;
            end else if (state == S_SCAN) begin
                primed <= 1'b1;
                if (advance)
                    idx <= last_lane ? '0 : idx + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (move_count != {CNT_W{1'b1}})
                    move_count <= move_count + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: snapshot and FIFO storage carry no reset; validity lives in the reset pointers
    // and m_data is gated to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (snap_load)
            for (int i = 0; i < NUM_LANES; i++)
                snap[i] <= moves_in[32*i +: 32];
        if (push)
            mem[wr_ptr[PTR_W-1:0]] <= lane_word;
    end

endmodule

// File: tb/tb_move_list_collector.sv
// Self-checking bench for move_list_collector: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations and a randomized phase.
module tb_move_list_collector;
    localparam int NL = 16;
    localparam int DP = 8;
    localparam int CW = 8;
`ifdef CAPTURE_FIRST_EN
    localparam bit CAP_FIRST = 1'b1;
`else
    localparam bit CAP_FIRST = 1'b0;
`endif
    localparam int SCAN_CYC   = CAP_FIRST ? 2 * NL : NL;
    localparam int DONE_EDGE  = SCAN_CYC + 2;
    // Edge after which a quiet, non-zero lane 0 is visible on m_valid.
    localparam int FIRST_EDGE = CAP_FIRST ? NL + 2 : 2;

    logic             clk = 1'b0;
    logic             clear_n = 1'b1;
    logic             start = 1'b0;
    logic             m_ready = 1'b0;
    logic [NL*32-1:0] moves_in = '0;
    logic             busy, m_valid, done;
    logic [31:0]      m_data;
    logic [CW-1:0]    move_count;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;
    logic [31:0] got [$];

    move_list_collector #(.NUM_LANES(NL), .DEPTH(DP), .CNT_W(CW)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .start      (start),
        .moves_in   (moves_in),
        .busy       (busy),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .move_count (move_count),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] q_fifo [$];
    logic [31:0] q_scan [$];
    bit          q_take [$];
    int          m_phase = 0;   // 0 idle, 1 collecting, 2 waiting for the FIFO to empty
    int          m_wait  = 0;
    int          m_count = 0;
    bit          m_done  = 1'b0;

    function automatic void plan(input logic [NL*32-1:0] mv);
        q_scan.delete();
        q_take.delete();
        for (int p = 0; p < (CAP_FIRST ? 2 : 1); p++) begin
            for (int i = 0; i < NL; i++) begin
                logic [31:0] w;
                bit          cap;
                w   = mv[32*i +: 32];
                cap = (w[29:24] != 6'd0);
                q_scan.push_back(w);
                if (!CAP_FIRST)
                    q_take.push_back(w != 32'd0);
                else if (p == 0)
                    q_take.push_back(cap);
                else
                    q_take.push_back((w != 32'd0) && !cap);
            end
        end
    endfunction

    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            q_fifo.delete();
            q_scan.delete();
            q_take.delete();
            m_phase = 0;
            m_wait  = 0;
            m_count = 0;
            m_done  = 1'b0;
        end else begin
            bit          pop, room, did_push;
            logic [31:0] pw;
            pop      = (q_fifo.size() > 0) && m_ready;
            room     = (q_fifo.size() < DP) || pop;
            did_push = 1'b0;
            pw       = '0;
            m_done   = 1'b0;
            if (m_phase == 0) begin
                if (start) begin
                    plan(moves_in);
                    m_count = 0;
                    m_wait  = 1;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (m_wait > 0) begin
                    m_wait--;
                end else begin
                    if (!q_take[0]) begin
                        void'(q_scan.pop_front());
                        void'(q_take.pop_front());
                    end else if (room) begin
                        pw = q_scan.pop_front();
                        void'(q_take.pop_front());
                        did_push = 1'b1;
                        if (m_count < (2 ** CW) - 1)
                            m_count++;
                    end
                    if (q_scan.size() == 0)
                        m_phase = 2;
                end
            end else begin
                if (q_fifo.size() == 0) begin
                    m_done  = 1'b1;
                    m_phase = 0;
                end
            end
            if (pop)
                void'(q_fifo.pop_front());
            if (did_push)
                q_fifo.push_back(pw);
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("m_valid", 32'(m_valid), 32'(q_fifo.size() > 0));
        check("m_data", m_data, (q_fifo.size() > 0) ? q_fifo[0] : 32'd0);
        check("move_count", 32'(move_count), 32'(m_count));
        check("done", 32'(done), 32'(m_done));
        if (done)
            done_seen++;
        if (m_valid && m_ready)
            got.push_back(m_data);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            tick();
            k++;
        end
        check(name, 32'(done), 32'd1);
        tick();
    endtask

    initial begin
        int d0;
        int done_at;
        bit mv_seen;

        #2 clear_n = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", m_data, 32'd0);
        check("rst_count", 32'(move_count), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        clear_n = 1'b1;
        tick();

        // Two moves, quiet one first in lane order.
        moves_in = '0;
        moves_in[32*2 +: 32] = 32'h0000_1815;
        moves_in[32*5 +: 32] = 32'h0114_1815;
        m_ready = 1'b1;
        got.delete();
        d0 = done_seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        moves_in = '1;
        wait_done("t2_done", 200);
        check("t2_count", 32'(move_count), 32'd2);
        check("t2_n", 32'(got.size()), 32'd2);
        check("t2_w0", (got.size() > 0) ? got[0] : 32'hDEAD_BEEF,
              CAP_FIRST ? 32'h0114_1815 : 32'h0000_1815);
        check("t2_w1", (got.size() > 1) ? got[1] : 32'hDEAD_BEEF,
              CAP_FIRST ? 32'h0000_1815 : 32'h0114_1815);
        check("t2_pulses", 32'(done_seen - d0), 32'd1);

        // All lanes non-zero with the consumer stalled: FIFO fills and the scan stalls.
        m_ready = 1'b0;
        for (int i = 0; i < NL; i++)
            moves_in[32*i +: 32] = 32'h0000_0100 + 32'(i);
        got.delete();
        d0 = done_seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= FIRST_EDGE; e++) begin
            tick();
            if (e == FIRST_EDGE - 1)
                check("t3_lat_pre", 32'(m_valid), 32'd0);
        end
        check("t3_lat", 32'(m_valid), 32'd1);
        check("t3_head", m_data, 32'h0000_0100);
        repeat (SCAN_CYC + 10) tick();
        check("t3_stall_count", 32'(move_count), 32'd8);
        check("t3_stall_busy", 32'(busy), 32'd1);
        check("t3_stall_head", m_data, 32'h0000_0100);
        check("t3_no_done", 32'(done_seen - d0), 32'd0);
        m_ready = 1'b1;
        tick();
        check("t6_push_pop_full", 32'(move_count), 32'd9);
        wait_done("t3_done", 200);
        check("t3_n", 32'(got.size()), 32'd16);
        for (int i = 0; i < NL; i++)
            check("t3_order", (got.size() > i) ? got[i] : 32'hDEAD_BEEF,
                  32'h0000_0100 + 32'(i));
        check("t3_count", 32'(move_count), 32'd16);
        check("t3_pulses", 32'(done_seen - d0), 32'd1);

        // All-zero snapshot: done timing only.
        moves_in = '0;
        m_ready  = 1'b1;
        d0       = done_seen;
        done_at  = -1;
        mv_seen  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= DONE_EDGE + 5; e++) begin
            tick();
            if (e == 1)
                check("t4_busy", 32'(busy), 32'd1);
            if (m_valid)
                mv_seen = 1'b1;
            if (done && done_at < 0)
                done_at = e;
        end
        check("t4_done_edge", 32'(done_at), 32'(DONE_EDGE));
        check("t4_no_valid", 32'(mv_seen), 32'd0);
        check("t4_count", 32'(move_count), 32'd0);
        check("t4_pulses", 32'(done_seen - d0), 32'd1);

        // Reset in the middle of a scan with three words queued.
        m_ready = 1'b0;
        for (int i = 0; i < NL; i++)
            moves_in[32*i +: 32] = 32'h0000_0300 + 32'(i);
        d0 = done_seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (FIRST_EDGE + 2) tick();
        check("t1_pre_count", 32'(move_count), 32'd3);
        #2 clear_n = 1'b0;
        #1;
        check("t1_valid", 32'(m_valid), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_count", 32'(move_count), 32'd0);
        check("t1_data", m_data, 32'd0);
        repeat (2) tick();
        clear_n = 1'b1;
        repeat (NL + 8) tick();
        check("t1_no_done", 32'(done_seen - d0), 32'd0);

        // Second start while busy, consumer toggling every cycle.
        for (int i = 0; i < NL; i++) begin
            logic [31:0] w;
            w = 32'h0000_0a00 | 32'(i);
            if (i % 2 == 1)
                w[29:24] = 6'(i);
            if (i % 3 == 0)
                w = '0;
            moves_in[32*i +: 32] = w;
        end
        got.delete();
        d0 = done_seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        moves_in = {NL{32'h0101_0101}};
        for (int c = 0; c < 400 && !done; c++) begin
            m_ready = c[0];
            start   = (c == 3);
            tick();
        end
        start = 1'b0;
        check("t5_done", 32'(done), 32'd1);
        tick();
        check("t5_n", 32'(got.size()), 32'd10);
        check("t5_count", 32'(move_count), 32'd10);
        check("t5_pulses", 32'(done_seen - d0), 32'd1);

        // Randomized collections against the model.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < NL; i++) begin
                logic [31:0] w;
                w = $urandom;
                if ($urandom_range(0, 1) == 1)
                    w[29:24] = 6'd0;
                if ($urandom_range(0, 2) == 0)
                    w = '0;
                moves_in[32*i +: 32] = w;
            end
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int c = 0; c < 600 && !done; c++) begin
                int j;
                m_ready = ($urandom_range(0, 3) != 0);
                start   = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 3) == 0) begin
                    j = $urandom_range(0, NL - 1);
                    moves_in[32*j +: 32] = $urandom;
                end
                tick();
            end
            start = 1'b0;
            check("rand_done", 32'(done), 32'd1);
            tick();
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
